// File: rtl/interleaver_pkg.sv
// Shared definitions for the convolutional interleaver datapath: default sizes,
// direction encodings and the start-branch rule used by every commutator.
package interleaver_pkg;

    localparam int DEFAULT_WIDTH    = 32'sd8;
    localparam int DEFAULT_BRANCHES = 32'sd12;

    localparam int DIR_INTERLEAVE   = 32'sd0;
    localparam int DIR_DEINTERLEAVE = 32'sd1;

    // The frame starts at the branch the pointer visits first in its direction.
    function automatic int start_branch(input int branches, input int dir);
        if (dir == DIR_DEINTERLEAVE) begin
            start_branch = branches - 32'sd1;
        end else begin
            start_branch = 32'sd0;
        end
    endfunction

endpackage

// File: rtl/branch_ptr_counter.sv
// Modulo-BRANCHES up/down branch pointer with advance enable, load-to-start
// and synchronous reset; shared by the read and write side commutators.
module branch_ptr_counter
    import interleaver_pkg::*;
#(
    parameter int BRANCHES = DEFAULT_BRANCHES,
    parameter int DIR      = DIR_INTERLEAVE,
    parameter int SEL_W    = $clog2(BRANCHES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    output logic [SEL_W-1:0] ptr
);

    localparam logic [SEL_W-1:0] START_PTR = SEL_W'(start_branch(BRANCHES, DIR));
    localparam logic [SEL_W-1:0] LAST_PTR  = SEL_W'(BRANCHES - 32'sd1);
    localparam logic [SEL_W-1:0] ZERO_PTR  = SEL_W'(1'b0);
    localparam logic [SEL_W-1:0] ONE_PTR   = SEL_W'(1'b1);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptr_nxt_s;

    // Next pointer: load beats advance; wrap keeps the value inside 0..BRANCHES-1.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (load) begin
            ptr_nxt_s = START_PTR;
        end else if (en) begin
            if (DIR == DIR_DEINTERLEAVE) begin
                ptr_nxt_s = (ptr_r == ZERO_PTR) ? LAST_PTR : (ptr_r - ONE_PTR);
            end else begin
                ptr_nxt_s = (ptr_r == LAST_PTR) ? ZERO_PTR : (ptr_r + ONE_PTR);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= START_PTR;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/interleaver_commutator.sv
// Registered branch commutator: picks one branch symbol per accept using a
// rotating pointer and holds it in a single valid/ready output register.
module interleaver_commutator
    import interleaver_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int BRANCHES = DEFAULT_BRANCHES,
    parameter int DIR      = DIR_INTERLEAVE,
    parameter int SEL_W    = $clog2(BRANCHES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BRANCHES*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      resync,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_branch,
    output logic                      out_sof
);

    localparam logic [SEL_W-1:0] START_PTR = SEL_W'(start_branch(BRANCHES, DIR));

    logic [SEL_W-1:0] ptr_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             drain_s;
    logic [WIDTH-1:0] sel_data_s;

    logic [WIDTH-1:0] out_data_r,   out_data_nxt_s;
    logic             out_valid_r,  out_valid_nxt_s;
    logic [SEL_W-1:0] out_branch_r, out_branch_nxt_s;
    logic             out_sof_r,    out_sof_nxt_s;

    // Ready only looks at the output register and downstream, never at in_valid/resync.
    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;
    assign drain_s    = out_valid_r && out_ready;
    assign sel_data_s = in_data[int'(ptr_s)*WIDTH +: WIDTH];

    branch_ptr_counter #(
        .BRANCHES (BRANCHES),
        .DIR      (DIR),
        .SEL_W    (SEL_W)
    ) u_ptr (
        .clk  (clk),
        .rst  (rst),
        .en   (accept_s),
        .load (resync),
        .ptr  (ptr_s)
    );

    // Output register next state: reload on accept, empty on a bare drain, else hold.
    always_comb begin
        out_data_nxt_s   = out_data_r;
        out_valid_nxt_s  = out_valid_r;
        out_branch_nxt_s = out_branch_r;
        out_sof_nxt_s    = out_sof_r;
        if (accept_s) begin
            out_data_nxt_s   = sel_data_s;
            out_valid_nxt_s  = 1'b1;
            out_branch_nxt_s = ptr_s;
            out_sof_nxt_s    = (ptr_s == START_PTR);
        end else if (drain_s) begin
            out_valid_nxt_s  = 1'b0;
        end else begin
            out_valid_nxt_s  = out_valid_r;
        end
    end

    // Output register; reset discards any held symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r   <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            out_branch_r <= START_PTR;
            out_sof_r    <= 1'b0;
        end else begin
            out_data_r   <= out_data_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_branch_r <= out_branch_nxt_s;
            out_sof_r    <= out_sof_nxt_s;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign out_branch = out_branch_r;
    assign out_sof    = out_sof_r;

endmodule

// File: tb/tb_interleaver_commutator.sv
// Directed bench for interleaver_commutator: interleave, deinterleave and a
// non-power-of-two instance driven from a single shared clock.
module tb_interleaver_commutator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [12*8-1:0]  data12;
    logic [5*16-1:0]  data5;

    logic        rst0 = 1'b1, iv0 = 1'b0, rs0 = 1'b0, ordy0 = 1'b0;
    logic        ir0, ov0, os0;
    logic [7:0]  od0;
    logic [3:0]  ob0;

    logic        rst1 = 1'b1, iv1 = 1'b0, rs1 = 1'b0, ordy1 = 1'b0;
    logic        ir1, ov1, os1;
    logic [7:0]  od1;
    logic [3:0]  ob1;

    logic        rst2 = 1'b1, iv2 = 1'b0, rs2 = 1'b0, ordy2 = 1'b0;
    logic        ir2, ov2, os2;
    logic [15:0] od2;
    logic [2:0]  ob2;

    interleaver_commutator #(.WIDTH(8), .BRANCHES(12), .DIR(0)) dut0 (
        .clk(clk), .rst(rst0), .in_data(data12), .in_valid(iv0), .in_ready(ir0),
        .resync(rs0), .out_data(od0), .out_valid(ov0), .out_ready(ordy0),
        .out_branch(ob0), .out_sof(os0));

    interleaver_commutator #(.WIDTH(8), .BRANCHES(12), .DIR(1)) dut1 (
        .clk(clk), .rst(rst1), .in_data(data12), .in_valid(iv1), .in_ready(ir1),
        .resync(rs1), .out_data(od1), .out_valid(ov1), .out_ready(ordy1),
        .out_branch(ob1), .out_sof(os1));

    interleaver_commutator #(.WIDTH(16), .BRANCHES(5), .DIR(0)) dut2 (
        .clk(clk), .rst(rst2), .in_data(data5), .in_valid(iv2), .in_ready(ir2),
        .resync(rs2), .out_data(od2), .out_valid(ov2), .out_ready(ordy2),
        .out_branch(ob2), .out_sof(os2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        step(); step();
        total++;
        if ({ov0, od0, ob0, os0} !== {1'b0, 8'h00, 4'd0, 1'b0})
            $display("FAIL reset_dut0 got v=%b d=%h b=%0d s=%b", ov0, od0, ob0, os0);
        else passed++;
        total++;
        if ({ov1, od1, ob1, os1} !== {1'b0, 8'h00, 4'd11, 1'b0})
            $display("FAIL reset_dut1 got v=%b d=%h b=%0d s=%b", ov1, od1, ob1, os1);
        else passed++;
        total++;
        if ({ov2, od2, ob2, os2} !== {1'b0, 16'h0000, 3'd0, 1'b0})
            $display("FAIL reset_dut2 got v=%b d=%h b=%0d s=%b", ov2, od2, ob2, os2);
        else passed++;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        #1;
        total++;
        if ({ir0, ir1, ir2} !== 3'b111)
            $display("FAIL reset_in_ready got %b exp 111", {ir0, ir1, ir2});
        else passed++;
    endtask

    task automatic test_interleave();
        iv0 = 1'b1; ordy0 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            int b;
            b = i % 12;
            step();
            total++;
            if ({ov0, ob0, os0, od0} !== {1'b1, 4'(b), (b == 0), 8'h10 + 8'(b)})
                $display("FAIL interleave_out[%0d] got v=%b b=%0d s=%b d=%h exp b=%0d d=%h",
                         i, ov0, ob0, os0, od0, b, 8'h10 + 8'(b));
            else passed++;
        end
        iv0 = 1'b0;
        step();
    endtask

    task automatic test_deinterleave();
        iv1 = 1'b1; ordy1 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            int b;
            b = 11 - (i % 12);
            step();
            total++;
            if ({ov1, ob1, os1, od1} !== {1'b1, 4'(b), (b == 11), 8'h10 + 8'(b)})
                $display("FAIL deinterleave_out[%0d] got v=%b b=%0d s=%b d=%h exp b=%0d d=%h",
                         i, ov1, ob1, os1, od1, b, 8'h10 + 8'(b));
            else passed++;
        end
        iv1 = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        rst0 = 1'b1; step(); rst0 = 1'b0;
        iv0 = 1'b1; ordy0 = 1'b1;
        step(); step(); step();
        total++;
        if (od0 !== 8'h12) $display("FAIL bp_third got %h exp 12", od0);
        else passed++;
        ordy0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({ir0, ov0, od0, ob0, dut0.ptr_s} !== {1'b0, 1'b1, 8'h12, 4'd2, 4'd3})
                $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h b=%0d ptr=%0d exp rdy=0 v=1 d=12 b=2 ptr=3",
                         i, ir0, ov0, od0, ob0, dut0.ptr_s);
            else passed++;
        end
        ordy0 = 1'b1;
        #1;
        total++;
        if (ir0 !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", ir0);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({ov0, od0} !== {1'b1, 8'h13 + 8'(i)})
                $display("FAIL bp_resume[%0d] got v=%b d=%h exp d=%h", i, ov0, od0, 8'h13 + 8'(i));
            else passed++;
        end
        iv0 = 1'b0;
        step();
    endtask

    task automatic test_resync();
        rst0 = 1'b1; step(); rst0 = 1'b0;
        iv0 = 1'b1; ordy0 = 1'b1;
        for (int i = 0; i < 7; i++) step();
        total++;
        if (dut0.ptr_s !== 4'd7) $display("FAIL resync_pre_ptr got %0d exp 7", dut0.ptr_s);
        else passed++;
        rs0 = 1'b1;
        step();
        total++;
        if ({ov0, ob0, os0, od0} !== {1'b1, 4'd7, 1'b0, 8'h17})
            $display("FAIL resync_accept got v=%b b=%0d s=%b d=%h exp b=7 s=0 d=17", ov0, ob0, os0, od0);
        else passed++;
        rs0 = 1'b0;
        step();
        total++;
        if ({ov0, ob0, os0, od0} !== {1'b1, 4'd0, 1'b1, 8'h10})
            $display("FAIL resync_next got v=%b b=%0d s=%b d=%h exp b=0 s=1 d=10", ov0, ob0, os0, od0);
        else passed++;
        step(); step(); step();
        total++;
        if ({ob0, dut0.ptr_s} !== {4'd3, 4'd4})
            $display("FAIL resync_mid got b=%0d ptr=%0d exp b=3 ptr=4", ob0, dut0.ptr_s);
        else passed++;
        iv0 = 1'b0; rs0 = 1'b1;
        step();
        total++;
        if ({ov0, ob0, dut0.ptr_s} !== {1'b0, 4'd3, 4'd0})
            $display("FAIL resync_idle got v=%b b=%0d ptr=%0d exp v=0 b=3 ptr=0", ov0, ob0, dut0.ptr_s);
        else passed++;
        rs0 = 1'b0; iv0 = 1'b1;
        step();
        total++;
        if ({ov0, ob0, os0, od0} !== {1'b1, 4'd0, 1'b1, 8'h10})
            $display("FAIL resync_idle_next got v=%b b=%0d s=%b d=%h exp b=0 s=1 d=10", ov0, ob0, os0, od0);
        else passed++;
        iv0 = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        rst1 = 1'b1; step(); rst1 = 1'b0;
        iv1 = 1'b1; ordy1 = 1'b1;
        step(); step();
        iv1 = 1'b0; ordy1 = 1'b0;
        step();
        total++;
        if ({ov1, od1, ob1} !== {1'b1, 8'h1A, 4'd10})
            $display("FAIL midrst_held got v=%b d=%h b=%0d exp v=1 d=1a b=10", ov1, od1, ob1);
        else passed++;
        rst1 = 1'b1;
        step();
        total++;
        if ({ov1, od1, ob1, os1, dut1.ptr_s} !== {1'b0, 8'h00, 4'd11, 1'b0, 4'd11})
            $display("FAIL midrst_cleared got v=%b d=%h b=%0d s=%b ptr=%0d exp v=0 d=00 b=11 s=0 ptr=11",
                     ov1, od1, ob1, os1, dut1.ptr_s);
        else passed++;
        rst1 = 1'b0; iv1 = 1'b1; ordy1 = 1'b1;
        step();
        total++;
        if ({ov1, ob1, os1, od1} !== {1'b1, 4'd11, 1'b1, 8'h1B})
            $display("FAIL midrst_first got v=%b b=%0d s=%b d=%h exp b=11 s=1 d=1b", ov1, ob1, os1, od1);
        else passed++;
        iv1 = 1'b0;
        step();
    endtask

    task automatic test_nonpow2();
        iv2 = 1'b1; ordy2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int b;
            b = i % 5;
            step();
            total++;
            if ({ov2, ob2, os2, od2} !== {1'b1, 3'(b), (b == 0), 16'hA000 + 16'(b)} || ob2 > 3'd4)
                $display("FAIL nonpow2_out[%0d] got v=%b b=%0d s=%b d=%h exp b=%0d d=%h",
                         i, ov2, ob2, os2, od2, b, 16'hA000 + 16'(b));
            else passed++;
        end
        iv2 = 1'b0;
        step();
    endtask

    initial begin
        for (int k = 0; k < 12; k++) data12[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 5; k++)  data5[k*16 +: 16] = 16'hA000 + 16'(k);
        test_reset();
        test_interleave();
        test_deinterleave();
        test_backpressure();
        test_resync();
        test_reset_midstream();
        test_nonpow2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
